// File: rtl/fp_wb_queue.sv
// fp_wb_queue: pairs FP instruction destination tags with FPU results and
// issues the register-file writeback in program order.
//
// Two FIFOs of DEPTH entries: a tag FIFO ({rd, int}) filled at issue and a
// result FIFO ({result, status}) filled by the FPU. When both heads exist the
// pair is presented: FP destinations write and pop immediately, integer
// destinations wait for int_wb_ready_i with valid/addr/data held stable.
// A result arriving with no tag to pair with is dropped and sets err_o (sticky).
//
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   issue_valid_i/rd_i/int_i/ready_o tag push side
//   fpu_valid_i/result_i/status_i/ready_o  result push side
//   flush_i                          empty both FIFOs at the next edge
//   fp_wb_valid_o/addr_o/data_o      FP register-file write
//   int_wb_valid_o/addr_o/data_o, int_wb_ready_i  integer writeback handshake
//   busy_o, err_o                    occupancy, sticky orphan-result error
//   fflags_o, fflags_clr_i           accumulated exception flags
//
// Optional feature: define FP_WB_FFLAGS_EN to store FPU status with each result
// and accumulate it into fflags_o on every pop. Without it fflags_o is 0.
module fp_wb_queue #(
   parameter int DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        issue_valid_i,
   input  logic [4:0]  issue_rd_i,
   input  logic        issue_int_i,
   output logic        issue_ready_o,
   input  logic        fpu_valid_i,
   input  logic [31:0] fpu_result_i,
   input  logic [4:0]  fpu_status_i,
   output logic        fpu_ready_o,
   input  logic        flush_i,
   output logic        fp_wb_valid_o,
   output logic [4:0]  fp_wb_addr_o,
   output logic [31:0] fp_wb_data_o,
   output logic        int_wb_valid_o,
   output logic [4:0]  int_wb_addr_o,
   output logic [31:0] int_wb_data_o,
   input  logic        int_wb_ready_i,
   output logic        busy_o,
   output logic        err_o,
   output logic [4:0]  fflags_o,
   input  logic        fflags_clr_i
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [4:0]    tag_rd_q   [DEPTH];
   logic          tag_int_q  [DEPTH];
   logic [31:0]   res_data_q [DEPTH];
   logic [PW-1:0] tag_wp_q, tag_rp_q, res_wp_q, res_rp_q;
   logic [CW-1:0] tag_cnt_q, res_cnt_q;
   logic          err_q;

   logic tag_push, res_hs, orphan, res_push, present, head_int, pop;
   logic [4:0]  head_rd;
   logic [31:0] head_data;

   // Ready depends only on registered occupancy, so a full FIFO never
   // accepts a push even in a cycle where it pops.
   assign issue_ready_o = (tag_cnt_q < DEPTH_C);
   assign fpu_ready_o   = (res_cnt_q < DEPTH_C);

   assign tag_push = issue_valid_i & issue_ready_o;
   assign res_hs   = fpu_valid_i & fpu_ready_o;
   // A result is an orphan only if no tag is stored and none arrives this cycle.
   assign orphan   = res_hs & (tag_cnt_q == '0) & ~tag_push;
   assign res_push = res_hs & ~orphan;

   assign head_rd   = tag_rd_q[tag_rp_q];
   assign head_int  = tag_int_q[tag_rp_q];
   assign head_data = res_data_q[res_rp_q];
   assign present   = (tag_cnt_q != '0) & (res_cnt_q != '0);
   assign pop       = present & (~head_int | int_wb_ready_i);

   assign fp_wb_valid_o  = present & ~head_int;
   assign fp_wb_addr_o   = fp_wb_valid_o ? head_rd : 5'd0;
   assign fp_wb_data_o   = fp_wb_valid_o ? head_data : 32'd0;
   assign int_wb_valid_o = present & head_int;
   assign int_wb_addr_o  = int_wb_valid_o ? head_rd : 5'd0;
   assign int_wb_data_o  = int_wb_valid_o ? head_data : 32'd0;

   assign busy_o = (tag_cnt_q != '0) | (res_cnt_q != '0);
   assign err_o  = err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            tag_rd_q[i]   <= '0;
            tag_int_q[i]  <= 1'b0;
            res_data_q[i] <= '0;
         end
         tag_wp_q  <= '0;
         tag_rp_q  <= '0;
         res_wp_q  <= '0;
         res_rp_q  <= '0;
         tag_cnt_q <= '0;
         res_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         if (orphan) err_q <= 1'b1;
         if (flush_i) begin
            tag_wp_q  <= '0;
            tag_rp_q  <= '0;
            res_wp_q  <= '0;
            res_rp_q  <= '0;
            tag_cnt_q <= '0;
            res_cnt_q <= '0;
         end else begin
            if (tag_push) begin
               tag_rd_q[tag_wp_q]  <= issue_rd_i;
               tag_int_q[tag_wp_q] <= issue_int_i;
               tag_wp_q            <= tag_wp_q + PW'(1);
            end
            if (res_push) begin
               res_data_q[res_wp_q] <= fpu_result_i;
               res_wp_q             <= res_wp_q + PW'(1);
            end
            if (pop) begin
               tag_rp_q <= tag_rp_q + PW'(1);
               res_rp_q <= res_rp_q + PW'(1);
            end
            tag_cnt_q <= tag_cnt_q + CW'(tag_push) - CW'(pop);
            res_cnt_q <= res_cnt_q + CW'(res_push) - CW'(pop);
         end
      end
   end

`ifdef FP_WB_FFLAGS_EN
   logic [4:0] res_st_q [DEPTH];
   logic [4:0] fflags_q;

   // Clear and pop in the same cycle leave exactly the popped status.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) res_st_q[i] <= '0;
         fflags_q <= '0;
      end else begin
         if (res_push && !flush_i) res_st_q[res_wp_q] <= fpu_status_i;
         fflags_q <= (fflags_clr_i ? 5'd0 : fflags_q) |
                     (pop ? res_st_q[res_rp_q] : 5'd0);
      end
   end
   assign fflags_o = fflags_q;
`else
   logic unused_status;
   assign unused_status = ^{fpu_status_i, fflags_clr_i};
   assign fflags_o = 5'd0;
`endif

endmodule

// File: tb/tb_fp_wb_queue.sv
module tb_fp_wb_queue;
   localparam int DEPTH = 2;
`ifdef FP_WB_FFLAGS_EN
   localparam bit FF_EN = 1'b1;
`else
   localparam bit FF_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid, issue_int, issue_ready;
   logic [4:0]  issue_rd;
   logic        fpu_valid, fpu_ready;
   logic [31:0] fpu_result;
   logic [4:0]  fpu_status;
   logic        flush;
   logic        fp_v, int_v, int_ready;
   logic [4:0]  fp_a, int_a;
   logic [31:0] fp_d, int_d;
   logic        busy, err, fflags_clr;
   logic [4:0]  fflags;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fp_wb_queue #(.DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .issue_int_i(issue_int),
      .issue_ready_o(issue_ready),
      .fpu_valid_i(fpu_valid), .fpu_result_i(fpu_result), .fpu_status_i(fpu_status),
      .fpu_ready_o(fpu_ready), .flush_i(flush),
      .fp_wb_valid_o(fp_v), .fp_wb_addr_o(fp_a), .fp_wb_data_o(fp_d),
      .int_wb_valid_o(int_v), .int_wb_addr_o(int_a), .int_wb_data_o(int_d),
      .int_wb_ready_i(int_ready), .busy_o(busy), .err_o(err),
      .fflags_o(fflags), .fflags_clr_i(fflags_clr)
   );

   task automatic idle();
      issue_valid = 0; issue_rd = 0; issue_int = 0;
      fpu_valid = 0; fpu_result = 0; fpu_status = 0;
      flush = 0; int_ready = 0; fflags_clr = 0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic issue(input logic [4:0] rd, input logic isint);
      issue_valid = 1; issue_rd = rd; issue_int = isint;
   endtask

   task automatic result(input logic [31:0] d, input logic [4:0] st);
      fpu_valid = 1; fpu_result = d; fpu_status = st;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 0;
      step(); step();
      rst_n = 1;
      step();
   endtask

   task automatic test_reset();
      idle();
      issue(5'd3, 1'b1);
      rst_n = 0;
      #7;
      checks++;
      if ({issue_ready, fpu_ready, fp_v, int_v, busy, err, fflags} !== {5'b11000, 1'b0, 5'd0}) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected %b",
                  {issue_ready, fpu_ready, fp_v, int_v, busy, err, fflags}, {5'b11000, 1'b0, 5'd0});
      end
      checks++;
      if ({fp_a, fp_d, int_a, int_d} !== 74'd0) begin
         errors++;
         $display("FAIL reset_data: got %h expected 0", {fp_a, fp_d, int_a, int_d});
      end
      idle();
      step();
      rst_n = 1;
      step();
   endtask

   task automatic test_fp_basic();
      idle();
      issue(5'd5, 1'b0);
      step();
      idle();
      result(32'h3F800000, 5'd0);
      checks++;
      if (fp_v !== 1'b0) begin
         errors++; $display("FAIL fp_basic_early: got %b expected 0", fp_v);
      end
      step();
      idle();
      checks++;
      if ({fp_v, fp_a, fp_d, int_v} !== {1'b1, 5'd5, 32'h3F800000, 1'b0}) begin
         errors++;
         $display("FAIL fp_basic_wb: got %h expected %h", {fp_v, fp_a, fp_d, int_v},
                  {1'b1, 5'd5, 32'h3F800000, 1'b0});
      end
      step();
      checks++;
      if ({fp_v, busy} !== 2'b00) begin
         errors++; $display("FAIL fp_basic_done: got %b expected 00", {fp_v, busy});
      end
   endtask

   task automatic test_int_stall();
      idle();
      issue(5'd10, 1'b1);
      step();
      idle();
      result(32'h7, 5'd0);
      step();
      idle();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({int_v, int_a, int_d, fp_v} !== {1'b1, 5'd10, 32'h7, 1'b0}) begin
            errors++;
            $display("FAIL int_stall_hold%0d: got %h expected %h", i, {int_v, int_a, int_d, fp_v},
                     {1'b1, 5'd10, 32'h7, 1'b0});
         end
         step();
      end
      int_ready = 1;
      step();
      int_ready = 0;
      checks++;
      if ({int_v, busy} !== 2'b00) begin
         errors++; $display("FAIL int_stall_pop: got %b expected 00", {int_v, busy});
      end
   endtask

   task automatic test_full();
      idle();
      issue(5'd1, 1'b0); step();
      issue(5'd2, 1'b0); step();
      idle();
      checks++;
      if ({issue_ready, busy, fp_v} !== 3'b010) begin
         errors++; $display("FAIL full_ready: got %b expected 010", {issue_ready, busy, fp_v});
      end
      issue(5'd3, 1'b0); step();
      idle();
      result(32'h11, 5'd0); step();
      result(32'h22, 5'd0);
      checks++;
      if ({fp_v, fp_a, fp_d} !== {1'b1, 5'd1, 32'h11}) begin
         errors++; $display("FAIL full_first: got %h expected %h", {fp_v, fp_a, fp_d}, {1'b1, 5'd1, 32'h11});
      end
      step();
      idle();
      checks++;
      if ({fp_v, fp_a, fp_d} !== {1'b1, 5'd2, 32'h22}) begin
         errors++; $display("FAIL full_second: got %h expected %h", {fp_v, fp_a, fp_d}, {1'b1, 5'd2, 32'h22});
      end
      step();
      checks++;
      if ({fp_v, busy, issue_ready, err} !== 4'b0010) begin
         errors++; $display("FAIL full_drained: got %b expected 0010", {fp_v, busy, issue_ready, err});
      end
   endtask

   task automatic test_orphan();
      idle();
      result(32'hDEAD, 5'd0); step();
      idle();
      checks++;
      if ({err, busy, fp_v, int_v} !== 4'b1000) begin
         errors++; $display("FAIL orphan_err: got %b expected 1000", {err, busy, fp_v, int_v});
      end
      issue(5'd7, 1'b0); step();
      idle();
      result(32'h1234, 5'd0); step();
      idle();
      checks++;
      if ({fp_v, fp_a, fp_d, err} !== {1'b1, 5'd7, 32'h1234, 1'b1}) begin
         errors++;
         $display("FAIL orphan_next: got %h expected %h", {fp_v, fp_a, fp_d, err}, {1'b1, 5'd7, 32'h1234, 1'b1});
      end
      step();
   endtask

   task automatic test_flush();
      idle();
      issue(5'd3, 1'b0); step();
      issue(5'd4, 1'b0); result(32'hA, 5'd0); step();
      idle();
      flush = 1;
      checks++;
      if ({fp_v, fp_a, fp_d} !== {1'b1, 5'd3, 32'hA}) begin
         errors++; $display("FAIL flush_cycle_wb: got %h expected %h", {fp_v, fp_a, fp_d}, {1'b1, 5'd3, 32'hA});
      end
      step();
      flush = 0;
      checks++;
      if ({busy, fp_v, int_v, issue_ready, fpu_ready, err} !== 6'b000111) begin
         errors++;
         $display("FAIL flush_empty: got %b expected 000111", {busy, fp_v, int_v, issue_ready, fpu_ready, err});
      end
      step();
      checks++;
      if ({busy, fp_v} !== 2'b00) begin
         errors++; $display("FAIL flush_after: got %b expected 00", {busy, fp_v});
      end
   endtask

   task automatic test_fflags();
      logic [4:0] e;
      do_reset();
      issue(5'd1, 1'b0); step();
      issue(5'd2, 1'b0); result(32'h1, 5'h01); step();
      idle();
      result(32'h2, 5'h10); step();
      idle();
      step();
      e = FF_EN ? 5'h11 : 5'h00;
      checks++;
      if ({fflags, busy} !== {e, 1'b0}) begin
         errors++; $display("FAIL fflags_accum: got %h expected %h", {fflags, busy}, {e, 1'b0});
      end
      issue(5'd3, 1'b0); step();
      idle();
      result(32'h3, 5'h04); step();
      idle();
      fflags_clr = 1;
      step();
      e = FF_EN ? 5'h04 : 5'h00;
      checks++;
      if (fflags !== e) begin
         errors++; $display("FAIL fflags_clr_pop: got %h expected %h", fflags, e);
      end
      step();
      fflags_clr = 0;
      checks++;
      if (fflags !== 5'h00) begin
         errors++; $display("FAIL fflags_clr: got %h expected 00", fflags);
      end
   endtask

   task automatic test_reset_stall();
      idle();
      issue(5'd9, 1'b1); step();
      idle();
      result(32'h55, 5'd0); step();
      idle();
      checks++;
      if ({int_v, int_a, int_d} !== {1'b1, 5'd9, 32'h55}) begin
         errors++; $display("FAIL rst_stall_pre: got %h expected %h", {int_v, int_a, int_d}, {1'b1, 5'd9, 32'h55});
      end
      #2 rst_n = 0;
      #1;
      checks++;
      if ({int_v, busy, issue_ready, fpu_ready} !== 4'b0011) begin
         errors++; $display("FAIL rst_stall_async: got %b expected 0011", {int_v, busy, issue_ready, fpu_ready});
      end
      step();
      rst_n = 1;
      int_ready = 1;
      step();
      checks++;
      if ({int_v, busy, err} !== 3'b000) begin
         errors++; $display("FAIL rst_stall_after: got %b expected 000", {int_v, busy, err});
      end
      idle();
   endtask

   typedef struct {logic [4:0] rd; logic isint;} tag_t;
   typedef struct {logic [31:0] d; logic [4:0] st;} res_t;

   task automatic test_random();
      tag_t tq[$];
      res_t rq[$];
      logic merr;
      logic [4:0] mflags;
      logic pres, pop, ia, fa, orphan;
      logic [84:0] exp_v, act_v;
      tag_t t;
      res_t r;
      do_reset();
      merr = 0; mflags = 0;
      for (int c = 0; c < 600; c++) begin
         issue_valid = 1'($urandom_range(0, 1));
         issue_rd    = 5'($urandom);
         issue_int   = 1'($urandom_range(0, 1));
         fpu_valid   = 1'($urandom_range(0, 1));
         fpu_result  = $urandom;
         fpu_status  = 5'($urandom);
         int_ready   = ($urandom_range(0, 3) != 0);
         flush       = ($urandom_range(0, 24) == 0);
         fflags_clr  = ($urandom_range(0, 9) == 0);
         #1;
         pres = (tq.size() > 0) && (rq.size() > 0);
         exp_v = '0;
         exp_v[84] = (tq.size() < DEPTH);
         exp_v[83] = (rq.size() < DEPTH);
         if (pres && !tq[0].isint) exp_v[82:45] = {1'b1, tq[0].rd, rq[0].d};
         if (pres && tq[0].isint)  exp_v[44:7]  = {1'b1, tq[0].rd, rq[0].d};
         exp_v[6] = (tq.size() > 0) || (rq.size() > 0);
         exp_v[5] = merr;
         exp_v[4:0] = mflags;
         act_v = {issue_ready, fpu_ready,
                  fp_v, fp_v ? fp_a : 5'd0, fp_v ? fp_d : 32'd0,
                  int_v, int_v ? int_a : 5'd0, int_v ? int_d : 32'd0,
                  busy, err, fflags};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL random_cycle%0d: got %h expected %h", c, act_v, exp_v);
         end
         pop = pres && (!tq[0].isint || int_ready);
         ia = issue_valid && (tq.size() < DEPTH);
         fa = fpu_valid && (rq.size() < DEPTH);
         orphan = fa && (tq.size() == 0) && !ia;
         if (FF_EN) mflags = (fflags_clr ? 5'd0 : mflags) | (pop ? rq[0].st : 5'd0);
         if (orphan) merr = 1;
         if (flush) begin
            tq.delete(); rq.delete();
         end else begin
            if (pop) begin
               void'(tq.pop_front()); void'(rq.pop_front());
            end
            if (ia) begin
               t.rd = issue_rd; t.isint = issue_int; tq.push_back(t);
            end
            if (fa && !orphan) begin
               r.d = fpu_result; r.st = fpu_status; rq.push_back(r);
            end
         end
         @(posedge clk); #1;
      end
      idle();
   endtask

   initial begin
      rst_n = 0;
      idle();
      test_reset();
      test_fp_basic();
      test_int_stall();
      test_full();
      test_orphan();
      test_flush();
      test_fflags();
      test_reset_stall();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
